// File: rtl/ref_fetch_ctrl.sv
// Reference-sample fetch controller: turns a 4x4 sub-block position and a
// 1/16-sample motion vector into a raster sequence of clamped read addresses.
//
// Ports:
//   CLK, RST_ASYNC_N      clock, asynchronous active-low reset
//   MV_VALID / MV_READY   sub-block command handshake (BLK_X/Y, MV_X/Y)
//   RD_EN / RD_READY      read-request handshake (RD_ADDR, RD_LAST)
//   FRAC_X / FRAC_Y       fractional phases of the block being fetched
module ref_fetch_ctrl #(
    parameter int PIC_W  = 128,
    parameter int PIC_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic                     CLK,
    input  logic                     RST_ASYNC_N,
    input  logic                     MV_VALID,
    output logic                     MV_READY,
    input  logic signed [7:0]        BLK_X,
    input  logic signed [7:0]        BLK_Y,
    input  logic signed [18:0]       MV_X,
    input  logic signed [18:0]       MV_Y,
    output logic                     RD_EN,
    input  logic                     RD_READY,
    output logic [ADDR_W-1:0]        RD_ADDR,
    output logic                     RD_LAST,
    output logic [3:0]               FRAC_X,
    output logic [3:0]               FRAC_Y
);

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_e;

    localparam logic signed [19:0] X_MAX = 20'(PIC_W - 1);
    localparam logic signed [19:0] Y_MAX = 20'(PIC_H - 1);
    localparam logic [ADDR_W-1:0]  XA_MAX = ADDR_W'(PIC_W - 1);
    localparam logic [ADDR_W-1:0]  YA_MAX = ADDR_W'(PIC_H - 1);
    localparam logic [ADDR_W-1:0]  PW     = ADDR_W'(PIC_W);

    state_e             state_q;
    logic signed [19:0] x0_q;
    logic signed [19:0] y0_q;
    logic [3:0]         col_q;
    logic [3:0]         row_q;
    logic               fx_q;
    logic               fy_q;
    logic [3:0]         frac_x_q;
    logic [3:0]         frac_y_q;

    logic               ix_d;
    logic               iy_d;
    logic signed [19:0] x0_d;
    logic signed [19:0] y0_d;
    logic               col_end;
    logic               row_end;
    logic signed [19:0] xs;
    logic signed [19:0] ys;
    logic [ADDR_W-1:0]  cx;
    logic [ADDR_W-1:0]  cy;

    // Window origin: the arithmetic shift floors the integer part, and a
    // fractional phase needs 3 extra taps on the leading side.
    always_comb begin
        ix_d = |MV_X[3:0];
        iy_d = |MV_Y[3:0];
        x0_d = $signed({{12{BLK_X[7]}}, BLK_X})
             + $signed({{5{MV_X[18]}}, MV_X[18:4]})
             - (ix_d ? 20'sd3 : 20'sd0);
        y0_d = $signed({{12{BLK_Y[7]}}, BLK_Y})
             + $signed({{5{MV_Y[18]}}, MV_Y[18:4]})
             - (iy_d ? 20'sd3 : 20'sd0);
    end

    assign col_end = (col_q == (fx_q ? 4'd10 : 4'd3));
    assign row_end = (row_q == (fy_q ? 4'd10 : 4'd3));

    // Edge padding: each coordinate clamps independently to the picture.
    always_comb begin
        xs = x0_q + $signed({16'b0, col_q});
        ys = y0_q + $signed({16'b0, row_q});
        if (xs < 20'sd0) begin
            cx = '0;
        end else if (xs > X_MAX) begin
            cx = XA_MAX;
        end else begin
            cx = ADDR_W'(xs);
        end
        if (ys < 20'sd0) begin
            cy = '0;
        end else if (ys > Y_MAX) begin
            cy = YA_MAX;
        end else begin
            cy = ADDR_W'(ys);
        end
    end

    assign MV_READY = (state_q == S_IDLE);
    assign RD_EN    = (state_q == S_FETCH);
    assign RD_LAST  = (state_q == S_FETCH) && col_end && row_end;
    assign RD_ADDR  = cy * PW + cx;
    assign FRAC_X   = frac_x_q;
    assign FRAC_Y   = frac_y_q;

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fx_q     <= 1'b0;
            fy_q     <= 1'b0;
            frac_x_q <= '0;
            frac_y_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (MV_VALID) begin
                        state_q  <= S_FETCH;
                        x0_q     <= x0_d;
                        y0_q     <= y0_d;
                        col_q    <= '0;
                        row_q    <= '0;
                        fx_q     <= ix_d;
                        fy_q     <= iy_d;
                        frac_x_q <= MV_X[3:0];
                        frac_y_q <= MV_Y[3:0];
                    end
                end
                S_FETCH: begin
                    if (RD_READY) begin
                        if (col_end) begin
                            col_q <= '0;
                            if (row_end) begin
                                row_q   <= '0;
                                state_q <= S_IDLE;
                            end else begin
                                row_q <= row_q + 4'd1;
                            end
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ref_fetch_ctrl.sv
// Directed bench for ref_fetch_ctrl: integer/fractional/negative MVs,
// backpressure, back-to-back commands and mid-window reset.
module tb_ref_fetch_ctrl;

    logic               CLK = 1'b0;
    logic               RST_ASYNC_N;
    logic               MV_VALID;
    logic               MV_READY;
    logic signed [7:0]  BLK_X;
    logic signed [7:0]  BLK_Y;
    logic signed [18:0] MV_X;
    logic signed [18:0] MV_Y;
    logic               RD_EN;
    logic               RD_READY;
    logic [13:0]        RD_ADDR;
    logic               RD_LAST;
    logic [3:0]         FRAC_X;
    logic [3:0]         FRAC_Y;

    int vectors = 0;
    int miscompares = 0;
    int got [0:127];
    int got_n;
    int stall_addr;

    always #5 CLK = ~CLK;

    ref_fetch_ctrl #(
        .PIC_W(128),
        .PIC_H(128),
        .ADDR_W(14)
    ) dut (
        .CLK(CLK),
        .RST_ASYNC_N(RST_ASYNC_N),
        .MV_VALID(MV_VALID),
        .MV_READY(MV_READY),
        .BLK_X(BLK_X),
        .BLK_Y(BLK_Y),
        .MV_X(MV_X),
        .MV_Y(MV_Y),
        .RD_EN(RD_EN),
        .RD_READY(RD_READY),
        .RD_ADDR(RD_ADDR),
        .RD_LAST(RD_LAST),
        .FRAC_X(FRAC_X),
        .FRAC_Y(FRAC_Y)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_addr(input int x0, input int y0,
                                      input int w, input int n);
        int x;
        int y;
        x = x0 + n % w;
        y = y0 + n / w;
        if (x < 0) x = 0;
        if (x > 127) x = 127;
        if (y < 0) y = 0;
        if (y > 127) y = 127;
        return y * 128 + x;
    endfunction

    // Called at a falling edge; command is accepted at the next rising edge.
    task automatic issue(input int bx, input int by, input int mx,
                         input int my, input bit keep);
        chk("mv_ready_idle", 32'(MV_READY), 32'd1);
        BLK_X = 8'(bx);
        BLK_Y = 8'(by);
        MV_X = 19'(mx);
        MV_Y = 19'(my);
        MV_VALID = 1'b1;
        @(negedge CLK);
        if (!keep) MV_VALID = 1'b0;
    endtask

    // Walks the window from the current falling edge; returns at the
    // falling edge after handshake number stop_n (or the last one).
    task automatic fetch(input int bx, input int by, input int mx,
                         input int my, input int stall_at,
                         input int stall_len, input int stop_n);
        int fx, fy, w, h, x0, y0, total, lim, n, st, cyc;
        fx = mx & 15;
        fy = my & 15;
        w = (fx != 0) ? 11 : 4;
        h = (fy != 0) ? 11 : 4;
        x0 = bx + (mx >>> 4) - ((fx != 0) ? 3 : 0);
        y0 = by + (my >>> 4) - ((fy != 0) ? 3 : 0);
        total = w * h;
        lim = (stop_n < total) ? stop_n : total;
        n = 0;
        st = 0;
        cyc = 0;
        chk("frac_x", 32'(FRAC_X), 32'(fx));
        chk("frac_y", 32'(FRAC_Y), 32'(fy));
        while (n < lim) begin
            cyc++;
            if (cyc > 400) begin
                vectors++;
                miscompares++;
                $error("FAIL timeout: observed %0d handshakes expected %0d",
                       n, lim);
                break;
            end
            chk("rd_en", 32'(RD_EN), 32'd1);
            chk("rd_addr", 32'(RD_ADDR), 32'(model_addr(x0, y0, w, n)));
            chk("rd_last", 32'(RD_LAST), 32'(n == total - 1));
            chk("mv_ready_busy", 32'(MV_READY), 32'd0);
            if (n == stall_at && st < stall_len) begin
                RD_READY = 1'b0;
                stall_addr = int'(RD_ADDR);
                st++;
            end else begin
                RD_READY = 1'b1;
                got[n] = int'(RD_ADDR);
                n++;
            end
            @(negedge CLK);
        end
        RD_READY = 1'b1;
        got_n = n;
    endtask

    initial begin
        RST_ASYNC_N = 1'b0;
        MV_VALID = 1'b0;
        RD_READY = 1'b1;
        BLK_X = '0;
        BLK_Y = '0;
        MV_X = '0;
        MV_Y = '0;
        stall_addr = -1;
        got_n = 0;

        #12;
        chk("rst_mv_ready", 32'(MV_READY), 32'd1);
        chk("rst_rd_en", 32'(RD_EN), 32'd0);
        chk("rst_rd_last", 32'(RD_LAST), 32'd0);
        chk("rst_rd_addr", 32'(RD_ADDR), 32'd0);
        chk("rst_frac_x", 32'(FRAC_X), 32'd0);
        chk("rst_frac_y", 32'(FRAC_Y), 32'd0);
        @(negedge CLK);
        RST_ASYNC_N = 1'b1;
        @(negedge CLK);

        // Integer MV, no stall
        issue(4, 8, 32, -16, 1'b0);
        fetch(4, 8, 32, -16, -1, 0, 999);
        chk("int_count", 32'(got_n), 32'd16);
        chk("int_first", 32'(got[0]), 32'd902);
        chk("int_last", 32'(got[15]), 32'd1289);
        chk("int_idle_rdy", 32'(MV_READY), 32'd1);
        chk("int_idle_en", 32'(RD_EN), 32'd0);

        // Horizontal fractional
        issue(4, 8, 8, 0, 1'b0);
        fetch(4, 8, 8, 0, -1, 0, 999);
        chk("hfr_count", 32'(got_n), 32'd44);
        chk("hfr_first", 32'(got[0]), 32'd1025);
        chk("hfr_row_end", 32'(got[10]), 32'd1035);
        chk("hfr_last", 32'(got[43]), 32'd1419);

        // Negative MV with left-edge clamping
        issue(0, 0, -40, 0, 1'b0);
        fetch(0, 0, -40, 0, -1, 0, 999);
        chk("neg_frac_x", 32'(FRAC_X), 32'd8);
        chk("neg_count", 32'(got_n), 32'd44);
        for (int i = 0; i < 7; i++) chk("neg_row0_pad", 32'(got[i]), 32'd0);
        for (int i = 7; i < 11; i++)
            chk("neg_row0", 32'(got[i]), 32'(i - 6));
        chk("neg_last", 32'(got[43]), 32'd388);

        // Backpressure: 3 stall cycles after 6 handshakes
        issue(4, 8, 32, -16, 1'b0);
        fetch(4, 8, 32, -16, 6, 3, 999);
        chk("bp_stall_addr", 32'(stall_addr), 32'd1032);
        chk("bp_count", 32'(got_n), 32'd16);
        chk("bp_first", 32'(got[0]), 32'd902);
        chk("bp_last", 32'(got[15]), 32'd1289);

        // Back-to-back: MV_VALID held, second command already on the bus
        issue(4, 8, 32, -16, 1'b1);
        BLK_X = 8'sd4;
        BLK_Y = 8'sd8;
        MV_X = 19'sd8;
        MV_Y = 19'sd0;
        fetch(4, 8, 32, -16, -1, 0, 999);
        chk("b2b_count", 32'(got_n), 32'd16);
        chk("b2b_bubble_rdy", 32'(MV_READY), 32'd1);
        chk("b2b_bubble_en", 32'(RD_EN), 32'd0);
        @(negedge CLK);
        MV_VALID = 1'b0;
        chk("b2b_second_en", 32'(RD_EN), 32'd1);
        chk("b2b_second_addr", 32'(RD_ADDR), 32'd1025);
        fetch(4, 8, 8, 0, -1, 0, 5);

        // Reset mid-window, between edges
        #2;
        RST_ASYNC_N = 1'b0;
        #1;
        chk("mid_rst_en", 32'(RD_EN), 32'd0);
        chk("mid_rst_rdy", 32'(MV_READY), 32'd1);
        chk("mid_rst_last", 32'(RD_LAST), 32'd0);
        chk("mid_rst_addr", 32'(RD_ADDR), 32'd0);
        chk("mid_rst_fx", 32'(FRAC_X), 32'd0);
        @(negedge CLK);
        RST_ASYNC_N = 1'b1;
        @(negedge CLK);

        // Fresh 2-D fractional block clamped at the bottom edge
        issue(100, 120, 40, 24, 1'b0);
        fetch(100, 120, 40, 24, -1, 0, 999);
        chk("post_count", 32'(got_n), 32'd121);
        chk("post_first", 32'(got[0]), 32'd15203);
        chk("post_last", 32'(got[120]), 32'd16365);
        chk("post_idle_rdy", 32'(MV_READY), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
